chain_xfer_ctrl: RTL and testbench
==================================

# chain_xfer_ctrl

Sequencer for the dataTran flip-flop transfer chain. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first onto the chain's serial input. It then recaptures the word from the chain output after the fixed pipeline delay and reports the recovered word with a loopback compare flag. It sits between the word-level producer and the dataTran instance and owns the chain's INPUT and set controls.

## Interface
- WIDTH, 8, bits per transfer word (≥2)
- CHAIN_DEPTH, 2, register stages between chain_in and chain_out (≥1)
- CLK  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on CLK rising edge
- tx_data  in  WIDTH  word to transfer; sampled on handshake
- tx_valid  in  1  producer has a word
- tx_ready  out  1  controller idle; accepts a word when tx_valid & tx_ready
- chain_in  out  1  serial bit to chain INPUT (registered)
- chain_set  out  1  to chain set; held 1 (inactive) at all times except reset, where it is 0
- chain_out  in  1  chain OUT
- rx_data  out  WIDTH  recovered word; holds until next rx_valid
- rx_valid  out  1  one-cycle pulse, rx_data/rx_err valid
- rx_err  out  1  rx_data != captured tx_data; valid with rx_valid, held after
- busy  out  1  transfer in progress (not IDLE)

## Operation
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE: tx_ready=1. On handshake, latch tx_data into shift register and into compare register, then go to SHIFT.
- SHIFT: drive bit k of word on chain_in, k=0..WIDTH-1, one bit per cycle; after bit WIDTH-1 go to DRAIN.
- DRAIN: chain_in=0; wait until last bit captured; go to DONE.
- DONE: rx_valid=1 for exactly one cycle, then IDLE.
- Capture: bit k sampled from chain_out and shifted in MSB-side (LSB-first arrival), independent of state, by a down-counter started at handshake.
- rx_err = (captured word != latched tx_data), registered with rx_valid.
- tx_valid while busy: ignored, tx_ready=0; no queuing.
- No backpressure on rx side; rx_valid is not held.
- Counters sized $clog2(WIDTH+CHAIN_DEPTH+2); no wrap within a transfer.

## Timing
- Handshake edge = E0. chain_in carries bit k after edge E0+k (k=0..WIDTH-1), 0 otherwise.
- chain_out sampled for bit k at edge E0+k+CHAIN_DEPTH+1.
- Last sample at E0+WIDTH+CHAIN_DEPTH; rx_valid high in the cycle after that edge.
- tx_ready high again the cycle after rx_valid; minimum accept-to-accept period WIDTH+CHAIN_DEPTH+2 cycles.
- Reset values (reset=0 at an edge): state IDLE, tx_ready=0 while reset low, then 1 the first cycle after release; chain_in=0, chain_set=0 during reset, then 1; rx_data=0, rx_valid=0, rx_err=0, busy=0.
- Reset mid-transfer: abort immediately, no rx_valid, rx_data not updated beyond reset value; next handshake starts a clean transfer.
- tx_valid asserted in the cycle reset releases: not accepted until tx_ready=1.

## Structure
- Package chain_xfer_pkg: state enum (IDLE/SHIFT/DRAIN/DONE), localparam for sample offset (CHAIN_DEPTH+1), and counter width function.
- One sub-module: chain_sipo, a WIDTH-bit serial-in shift register with sample enable and clear, used for capture; serialiser stays inline.

## Test plan
- Reset held 4 cycles, then released -> all outputs at reset values, chain_set 0→1, tx_ready 1 one cycle after release.
- Loopback dataTran, tx_data=8'hA5 -> chain_in sequence 1,0,1,0,0,1,0,1 after E0..E7; rx_valid at cycle E0+11; rx_data=8'hA5; rx_err=0.
- chain_out forced 0 via fault inject, tx_data=8'hFF -> rx_data=8'h00, rx_err=1.
- Two handshakes 8'h01, 8'h80 with tx_valid held high -> second accepted exactly 12 cycles after first; both recovered, no overlap on chain_in.
- reset pulsed low at E0+5 during 8'h3C -> no rx_valid, chain_in 0, busy 0; following 8'hC3 recovered correctly.
- WIDTH=4, CHAIN_DEPTH=3 build, tx_data=4'h9 -> rx_valid in cycle after E0+7, rx_data=4'h9.

Source files
------------

// File: rtl/chain_xfer_pkg.sv
// Shared types and sizing helpers for the dataTran chain transfer controller.
// The sample offset is the extra cycle between a bit leaving the chain and its capture.
package chain_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

    localparam int SAMPLE_SLACK = 1;

    function automatic int sample_offset(input int depth);
        return depth + SAMPLE_SLACK;
    endfunction

    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 2);
    endfunction

endpackage

// File: rtl/chain_sipo.sv
// Serial-in shift register that rebuilds an LSB-first word from the chain output.
// next_word exposes the value being loaded so the final bit can be reported in the same cycle.
module chain_sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_word
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clear) begin
            word_d = '0;
        end else if (sample_en) begin
            word_d = {serial_in, word_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign next_word = word_d;

endmodule

// File: rtl/chain_xfer_ctrl.sv
// Serialises a word LSB-first into the dataTran chain and recaptures it after the chain delay,
// flagging any difference between the sent and recovered word.
module chain_xfer_ctrl
    import chain_xfer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHAIN_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             chain_in,
    output logic             chain_set,
    input  logic             chain_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_err,
    output logic             busy
);

    localparam int CNT_W         = cnt_width(WIDTH, CHAIN_DEPTH);
    localparam int SAMPLE_OFFSET = sample_offset(CHAIN_DEPTH);

    localparam logic [CNT_W-1:0] CNT_START    = CNT_W'(WIDTH + CHAIN_DEPTH);
    localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(SAMPLE_OFFSET);
    localparam logic [CNT_W-1:0] SAMPLE_FIRST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    xfer_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] expect_q, expect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chain_in_q, chain_in_d;
    logic             live_q, live_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_err_q, rx_err_d;

    logic             handshake;
    logic             sample_en;
    logic [WIDTH-1:0] cap_next;

    assign handshake = tx_valid && tx_ready;
    // One counter drives both the serialiser and the capture window, so capture keeps
    // going regardless of which state the FSM is in.
    assign sample_en = (cnt_q != '0) && (cnt_q <= SAMPLE_FIRST);

    chain_sipo #(.WIDTH(WIDTH)) u_sipo (
        .clk       (CLK),
        .clear     (!reset),
        .sample_en (sample_en),
        .serial_in (chain_out),
        .next_word (cap_next)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        expect_d   = expect_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        chain_in_d = 1'b0;
        live_d     = 1'b1;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    shift_d    = tx_data;
                    expect_d   = tx_data;
                    chain_in_d = tx_data[0];
                    cnt_d      = CNT_START;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = DRAIN;
                end else begin
                    chain_in_d = shift_q[1];
                    shift_d    = shift_q >> 1;
                end
            end
            DRAIN: begin
                // cnt_q of one marks the edge that captures the final bit
                if (cnt_q == CNT_ONE) begin
                    rx_data_d = cap_next;
                    rx_err_d  = (cap_next != expect_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            expect_q   <= '0;
            cnt_q      <= '0;
            chain_in_q <= 1'b0;
            live_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            expect_q   <= expect_d;
            cnt_q      <= cnt_d;
            chain_in_q <= chain_in_d;
            live_q     <= live_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign tx_ready  = (state_q == IDLE) && live_q;
    assign chain_in  = chain_in_q;
    assign chain_set = live_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = (state_q == DONE);
    assign rx_err    = rx_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chain_xfer_ctrl.sv
// Scoreboard bench for chain_xfer_ctrl: directed words go in, a loopback chain model
// feeds chain_out, and monitors compare every rx_valid against queued expectations.
module tb_chain_xfer_ctrl;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int W4 = 4;
    localparam int D4 = 3;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } want_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         chain_in;
    logic         chain_set;
    logic         chain_out;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_err;
    logic         busy;

    logic [W4-1:0] s_tx_data;
    logic          s_tx_valid;
    logic          s_tx_ready;
    logic          s_chain_in;
    logic          s_chain_set;
    logic          s_chain_out;
    logic [W4-1:0] s_rx_data;
    logic          s_rx_valid;
    logic          s_rx_err;
    logic          s_busy;

    logic          fault = 1'b0;
    logic [D-1:0]  pipe8 = '0;
    logic [D4-1:0] pipe4 = '0;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int last_e0 = 0;

    want_t sb8[$];
    want_t sb4[$];

    chain_xfer_ctrl #(.WIDTH(W), .CHAIN_DEPTH(D)) dut (
        .CLK       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .chain_in  (chain_in),
        .chain_set (chain_set),
        .chain_out (chain_out),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .busy      (busy)
    );

    chain_xfer_ctrl #(.WIDTH(W4), .CHAIN_DEPTH(D4)) dut4 (
        .CLK       (clk),
        .reset     (reset),
        .tx_data   (s_tx_data),
        .tx_valid  (s_tx_valid),
        .tx_ready  (s_tx_ready),
        .chain_in  (s_chain_in),
        .chain_set (s_chain_set),
        .chain_out (s_chain_out),
        .rx_data   (s_rx_data),
        .rx_valid  (s_rx_valid),
        .rx_err    (s_rx_err),
        .busy      (s_busy)
    );

    // Loopback stand-ins for the dataTran chains, with a stuck-at-0 fault on the wide one
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pipe8 <= {pipe8[D-2:0], chain_in};
        pipe4 <= {pipe4[D4-2:0], s_chain_in};
    end
    assign chain_out   = fault ? 1'b0 : pipe8[D-1];
    assign s_chain_out = pipe4[D4-1];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        want_t e;
        if (rx_valid === 1'b1) begin
            if (sb8.size() == 0) begin
                check_output("rx8_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb8.pop_front();
                check_output("rx8_data", {24'd0, rx_data}, {24'd0, e.data});
                check_output("rx8_err", {31'd0, rx_err}, {31'd0, e.err});
                check_output("rx8_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        want_t e;
        if (s_rx_valid === 1'b1) begin
            if (sb4.size() == 0) begin
                check_output("rx4_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb4.pop_front();
                check_output("rx4_data", {28'd0, s_rx_data}, {24'd0, e.data});
                check_output("rx4_err", {31'd0, s_rx_err}, {31'd0, e.err});
                check_output("rx4_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] data, input bit keep_valid);
        int waited;
        want_t e;
        waited = 0;
        @(negedge clk);
        tx_data  = data;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check_output("tx8_ready_timeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_e0 = cyc;
        e.data = fault ? 8'h00 : data;
        e.err  = fault && (data != 8'h00);
        e.cyc  = last_e0 + W + D + 1;
        sb8.push_back(e);
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_valid) tx_valid = 1'b0;
            check_output($sformatf("chain_in_bit%0d", k), {31'd0, chain_in},
                         {31'd0, (k < W) ? data[k] : 1'b0});
        end
    endtask

    task automatic apply_stimulus4(input logic [3:0] data);
        int waited;
        want_t e;
        waited = 0;
        @(negedge clk);
        s_tx_data  = data;
        s_tx_valid = 1'b1;
        while (s_tx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check_output("tx4_ready_timeout", 32'd0, 32'd1);
            s_tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.data = {4'd0, data};
        e.err  = 1'b0;
        e.cyc  = cyc + W4 + D4 + 1;
        sb4.push_back(e);
        @(negedge clk);
        s_tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((sb8.size() != 0 || sb4.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("scoreboard_drained", sb8.size() + sb4.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0_first;
        reset      = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        s_tx_data  = '0;
        s_tx_valid = 1'b0;

        repeat (4) @(negedge clk);
        check_output("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check_output("rst_chain_set", {31'd0, chain_set}, 32'd0);
        check_output("rst_chain_in", {31'd0, chain_in}, 32'd0);
        check_output("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check_output("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_output("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst4_busy", {31'd0, s_busy}, 32'd0);

        reset    = 1'b1;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_output("rel_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_output("rel_not_accepted", {31'd0, busy}, 32'd0);
        check_output("rel_chain_set", {31'd0, chain_set}, 32'd1);
        check_output("rel4_chain_set", {31'd0, s_chain_set}, 32'd1);

        apply_stimulus(8'hA5, 1'b0);
        wait_drain();

        fault = 1'b1;
        apply_stimulus(8'hFF, 1'b0);
        wait_drain();
        fault = 1'b0;

        apply_stimulus(8'h01, 1'b1);
        e0_first = last_e0;
        apply_stimulus(8'h80, 1'b0);
        check_output("b2b_gap", last_e0 - e0_first, 32'd12);
        wait_drain();

        // Start 8'h3C, then pull reset so that edge E0+5 samples it low
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_chain_in", {31'd0, chain_in}, 32'd0);
        check_output("abort_tx_ready", {31'd0, tx_ready}, 32'd0);
        check_output("abort_rx_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        check_output("abort_rx_hold", {24'd0, rx_data}, 32'd0);
        apply_stimulus(8'hC3, 1'b0);
        wait_drain();

        apply_stimulus4(4'h9);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
